mem_wb_queue_mt: RTL

- Parametrised, multithreaded successor to the mem-stage write-back glue.
- Takes a completed mem-stage result (ALU result or d-cache load data, selected by `is_mem_access`) and queues it in a DEPTH-entry FIFO tagged by thread.
- Drains one entry per cycle to the register-file write port when that port is granted.
- Supports per-thread flush of queued results and reports per-thread pending writes to the hazard controller.

---
 rtl/mem_wb_queue_mt.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_wb_queue_mt.sv
// Thread-tagged write-back queue between the mem stage and the register-file write port.
// Results are queued per thread, drained one per cycle on grant, and can be flushed per thread.
module mem_wb_queue_mt #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_THREADS    = 2,
  parameter int TID_WIDTH      = $clog2(NUM_THREADS),
  parameter int DEPTH          = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  input  logic                       i_is_mem_access,
  input  logic                       i_uses_rw,
  input  logic [REG_ADDR_WIDTH-1:0]  i_rw_addr,
  input  logic [DATA_WIDTH-1:0]      i_alu_result,
  input  logic [TID_WIDTH-1:0]       i_thread_id,
  input  logic                       i_cache_valid,
  input  logic [DATA_WIDTH-1:0]      i_cache_data,
  output logic                       o_done,
  input  logic                       i_flush,
  input  logic [TID_WIDTH-1:0]       i_flush_tid,
  output logic                       o_wb_valid,
  output logic [REG_ADDR_WIDTH-1:0]  o_wb_rw_addr,
  output logic [DATA_WIDTH-1:0]      o_wb_rw_data,
  output logic [TID_WIDTH-1:0]       o_wb_thread_id,
  input  logic                       i_wb_ready,
  output logic [NUM_THREADS-1:0]     o_thread_pending,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]          live_q;
  logic [DEPTH-1:0]          live_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0]     data_q [DEPTH];
  logic [TID_WIDTH-1:0]      tid_q  [DEPTH];
  logic [TID_WIDTH-1:0]      tid_d  [DEPTH];
  logic [PTR_W-1:0]          head_q;
  logic [PTR_W-1:0]          tail_q;
  logic [CNT_W-1:0]          count_q;
  logic [NUM_THREADS-1:0]    pending_q;
  logic [NUM_THREADS-1:0]    pending_d;

  logic                      result_ready;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic                      not_empty;
  logic                      full;
  logic                      head_live;
  logic                      pop;
  logic                      dropped;
  logic                      push;

  assign result_ready = i_is_mem_access ? i_cache_valid : 1'b1;
  assign wb_data      = i_is_mem_access ? i_cache_data : i_alu_result;
  assign not_empty    = (count_q != '0);
  assign full         = (count_q == CNT_W'(DEPTH));
  assign head_live    = live_q[head_q];
  // Dead heads leave without needing the write port.
  assign pop          = not_empty && (!head_live || i_wb_ready);
  assign dropped      = i_flush && (i_flush_tid == i_thread_id);
  assign push         = i_valid && i_uses_rw && result_ready && !dropped && (!full || pop);

  // rst_n gating keeps o_done low while the incoming instruction is being ignored.
  assign o_done = rst_n && (!i_valid ||
                  (result_ready && (!i_uses_rw || dropped || !full || pop)));

  assign o_wb_valid       = not_empty && head_live;
  assign o_wb_rw_addr     = addr_q[head_q];
  assign o_wb_rw_data     = data_q[head_q];
  assign o_wb_thread_id   = tid_q[head_q];
  assign o_thread_pending = pending_q;
  assign o_count          = count_q;

  // Next-state live bits: flush and pop kill, push revives the tail slot last.
  always_comb begin
    live_d    = live_q;
    pending_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tid_d[i] = tid_q[i];
      if (i_flush && (tid_q[i] == i_flush_tid)) live_d[i] = 1'b0;
      if (pop && (PTR_W'(i) == head_q))         live_d[i] = 1'b0;
      if (push && (PTR_W'(i) == tail_q)) begin
        live_d[i] = 1'b1;
        tid_d[i]  = i_thread_id;
      end
    end
    for (int t = 0; t < NUM_THREADS; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (live_d[i] && (tid_d[i] == TID_WIDTH'(t))) pending_d[t] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        tid_q[i]  <= '0;
      end
    end else begin
      live_q    <= live_d;
      pending_q <= pending_d;
      if (push) begin
        addr_q[tail_q] <= i_rw_addr;
        data_q[tail_q] <= wb_data;
        tid_q[tail_q]  <= i_thread_id;
        tail_q         <= tail_q + PTR_W'(1);
      end
      if (pop) head_q <= head_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule
